// File: rtl/timer_seg_display.sv
// timer_seg_display: drives a 4-digit common-anode seven-segment display
// from the 5-bit countdown seconds value and the pause flag.
//   digit 0: ones, digit 1: tens (blank when zero), digits 3..2: "--" while paused.
// Optional low-time blink of digits 1..0 is enabled by defining the macro
// TIMER_SEG_DISPLAY_BLINK_EN; without it the display is always steady.
module timer_seg_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50000000,
  parameter int WARN_THRESH = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] time_display,
  input  logic       pause,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Glyph table, active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Anode pattern for a digit index, active-low one-hot.
  function automatic logic [3:0] anode(input logic [1:0] idx);
    logic [3:0] a;
    case (idx)
      2'd0:    a = 4'b1110;
      2'd1:    a = 4'b1101;
      2'd2:    a = 4'b1011;
      default: a = 4'b0111;
    endcase
    return a;
  endfunction

  logic [4:0]    time_q;
  logic          pause_q;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          lit_q, lit_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          ref_wrap;
  logic [1:0]    tens;
  logic [3:0]    ones;
  logic [6:0]    digit_seg;
  logic          hide_low;

`ifdef TIMER_SEG_DISPLAY_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic          blink_wrap;

  // Blink timebase: free-running half-period counter and phase toggle.
  always_comb begin
    blink_wrap    = (blink_cnt_q == BW'(BLINK_DIV - 1));
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BW'(1);
    blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;
    // Using the next phase keeps every cycle of a lit slot consistent,
    // since both counters are aligned from reset.
    hide_low      = blink_phase_d && !pause_q && (time_q != 5'd0) &&
                    (int'(time_q) <= WARN_THRESH);
  end

  // Blink counter and phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`else
  assign hide_low = 1'b0;
`endif

  // Scan sequencing and next segment/anode pattern for the upcoming digit.
  always_comb begin
    ref_wrap  = (ref_cnt_q == RW'(REFRESH_DIV - 1));
    ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + RW'(1);
    idx_d     = ref_wrap ? idx_q + 2'd1 : idx_q;
    // The display stays dark until the first refresh wrap after reset.
    lit_d     = lit_q | ref_wrap;

    tens      = 2'(time_q / 5'd10);
    ones      = 4'(time_q % 5'd10);

    digit_seg = SEG_BLANK;
    case (idx_d)
      2'd0:    digit_seg = hide_low ? SEG_BLANK : glyph(ones);
      2'd1:    digit_seg = (hide_low || tens == 2'd0) ? SEG_BLANK : glyph({2'b00, tens});
      default: digit_seg = pause_q ? SEG_DASH : SEG_BLANK;
    endcase

    an_d  = lit_d ? anode(idx_d) : 4'b1111;
    seg_d = lit_d ? digit_seg : SEG_BLANK;
  end

  // Input capture, scan state and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_q    <= 5'd0;
      pause_q   <= 1'b0;
      ref_cnt_q <= '0;
      idx_q     <= 2'd0;
      lit_q     <= 1'b0;
      an_q      <= 4'b1111;
      seg_q     <= SEG_BLANK;
    end else begin
      time_q    <= time_display;
      pause_q   <= pause;
      ref_cnt_q <= ref_cnt_d;
      idx_q     <= idx_d;
      lit_q     <= lit_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_timer_seg_display.sv
module tb_timer_seg_display;

  localparam int RD = 4;
  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] time_display;
  logic       pause;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  timer_seg_display #(.REFRESH_DIV(RD), .BLINK_DIV(BD), .WARN_THRESH(5)) dut (
    .clk(clk), .rst_n(rst_n), .time_display(time_display), .pause(pause),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  // Edges since reset release, used to predict the blink phase.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Advance to the first negedge of the next slot whose anode equals target.
  task automatic wait_slot(input logic [3:0] target, output bit ok);
    int n = 0;
    while (an === target && n < 64) begin @(negedge clk); n++; end
    while (an !== target && n < 64) begin @(negedge clk); n++; end
    ok = (an === target);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; time_display = 5'd0; pause = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    time_display = 5'd23;
    repeat (10) @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    total++; if (an !== 4'b1111) begin bad++; $display("FAIL reset_an actual=%b required=1111", an); end
    total++; if (seg !== 7'b1111111) begin bad++; $display("FAIL reset_seg actual=%b required=1111111", seg); end
    total++; if (dp !== 1'b1) begin bad++; $display("FAIL reset_dp actual=%b required=1", dp); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (an !== 4'b1111) begin bad++; $display("FAIL post_reset_dark k=%0d actual=%b required=1111", k, an); end
    end
    @(negedge clk);
    total++; if (an !== 4'b1101) begin bad++; $display("FAIL first_lit_an actual=%b required=1101", an); end
    total++; if (seg !== 7'b0100100) begin bad++; $display("FAIL first_lit_seg actual=%b required=0100100", seg); end
  endtask

  task automatic test_scan_23;
    logic [3:0] exp_an  [4];
    logic [6:0] exp_seg [4];
    exp_an[0] = 4'b1101; exp_seg[0] = 7'b0100100;
    exp_an[1] = 4'b1011; exp_seg[1] = 7'b1111111;
    exp_an[2] = 4'b0111; exp_seg[2] = 7'b1111111;
    exp_an[3] = 4'b1110; exp_seg[3] = 7'b0110000;
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 4; s++)
        for (int k = 0; k < 4; k++) begin
          total++;
          if (an !== exp_an[s] || seg !== exp_seg[s] || dp !== 1'b1) begin
            bad++;
            $display("FAIL scan23 r=%0d s=%0d k=%0d actual=%b/%b/%b required=%b/%b/1",
                     r, s, k, an, seg, dp, exp_an[s], exp_seg[s]);
          end
          @(negedge clk);
        end
  endtask

  task automatic test_values;
    bit ok;
    time_display = 5'd7; pause = 1'b0;
    wait_slot(4'b1101, ok);
    total++; if (!ok || seg !== 7'b1111111) begin bad++; $display("FAIL v7_tens actual=%b required=1111111 found=%0d", seg, ok); end
    wait_slot(4'b1110, ok);
    total++; if (!ok || seg !== 7'b1111000) begin bad++; $display("FAIL v7_ones actual=%b required=1111000 found=%0d", seg, ok); end
    time_display = 5'd31;
    wait_slot(4'b1110, ok);
    total++; if (!ok || seg !== 7'b1111001) begin bad++; $display("FAIL v31_ones actual=%b required=1111001 found=%0d", seg, ok); end
    wait_slot(4'b1101, ok);
    total++; if (!ok || seg !== 7'b0110000) begin bad++; $display("FAIL v31_tens actual=%b required=0110000 found=%0d", seg, ok); end
    wait_slot(4'b1011, ok);
    total++; if (!ok || seg !== 7'b1111111) begin bad++; $display("FAIL v31_d2_nopause actual=%b required=1111111 found=%0d", seg, ok); end
  endtask

  task automatic test_pause_zero;
    bit ok;
    time_display = 5'd0; pause = 1'b1;
    wait_slot(4'b1011, ok);
    total++; if (!ok || seg !== 7'b0111111) begin bad++; $display("FAIL pz_d2 actual=%b required=0111111 found=%0d", seg, ok); end
    wait_slot(4'b0111, ok);
    total++; if (!ok || seg !== 7'b0111111) begin bad++; $display("FAIL pz_d3 actual=%b required=0111111 found=%0d", seg, ok); end
    wait_slot(4'b1110, ok);
    total++; if (!ok || seg !== 7'b1000000) begin bad++; $display("FAIL pz_d0 actual=%b required=1000000 found=%0d", seg, ok); end
    wait_slot(4'b1101, ok);
    total++; if (!ok || seg !== 7'b1111111) begin bad++; $display("FAIL pz_d1 actual=%b required=1111111 found=%0d", seg, ok); end
    pause = 1'b0;
  endtask

  task automatic test_blink;
    bit ok;
    logic [6:0] exp;
    // Low value, running: blinks only when the feature is built in.
    time_display = 5'd4; pause = 1'b0;
    for (int slot = 0; slot < 3; slot++) begin
      wait_slot(4'b1110, ok);
      total++; if (!ok) begin bad++; $display("FAIL blink_slot_timeout slot=%0d", slot); end
      for (int k = 0; k < 4; k++) begin
`ifdef TIMER_SEG_DISPLAY_BLINK_EN
        exp = (((cyc / BD) % 2) == 1) ? 7'b1111111 : 7'b0011001;
`else
        exp = 7'b0011001;
`endif
        total++;
        if (seg !== exp) begin bad++; $display("FAIL blink_run slot=%0d k=%0d actual=%b required=%b", slot, k, seg, exp); end
        @(negedge clk);
      end
    end
    // Paused: always steady.
    pause = 1'b1;
    for (int slot = 0; slot < 2; slot++) begin
      wait_slot(4'b1110, ok);
      for (int k = 0; k < 4; k++) begin
        total++;
        if (!ok || seg !== 7'b0011001) begin bad++; $display("FAIL blink_paused slot=%0d k=%0d actual=%b required=0011001", slot, k, seg); end
        @(negedge clk);
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_change;
    bit ok;
    logic [3:0] exp_an  [4];
    logic [6:0] exp_seg [4];
    exp_an[0] = 4'b1011; exp_seg[0] = 7'b1111111;
    exp_an[1] = 4'b0111; exp_seg[1] = 7'b1111111;
    exp_an[2] = 4'b1110; exp_seg[2] = 7'b0010000;
    exp_an[3] = 4'b1101; exp_seg[3] = 7'b1111111;
    time_display = 5'd10; pause = 1'b0;
    wait_slot(4'b1101, ok);
    total++; if (!ok || seg !== 7'b1111001) begin bad++; $display("FAIL chg_tens10 actual=%b required=1111001 found=%0d", seg, ok); end
    wait_slot(4'b1011, ok);
    total++; if (!ok) begin bad++; $display("FAIL chg_wait_timeout"); end
    time_display = 5'd9;
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 4; k++) begin
        total++;
        if (an !== exp_an[s] || seg !== exp_seg[s]) begin
          bad++;
          $display("FAIL chg_seq s=%0d k=%0d actual=%b/%b required=%b/%b", s, k, an, seg, exp_an[s], exp_seg[s]);
        end
        @(negedge clk);
      end
  endtask

  initial begin
    test_reset();
    test_scan_23();
    test_values();
    test_pause_zero();
    test_blink();
    test_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
